// File: rtl/net_cfg_sequencer_if.sv
// rtl/net_cfg_sequencer_if.sv - config-table, beat-request and switch-control bundle for net_cfg_sequencer
interface net_cfg_sequencer_if #(
    parameter int SWITCH_NUM = 16,
    parameter int STAGE_NUM  = 9,
    parameter int CFG_AW     = 3,
    parameter int SAW        = 4
);
    logic                  cfg_we;
    logic [CFG_AW-1:0]     cfg_waddr;
    logic [SAW-1:0]        cfg_wstage;
    logic [SWITCH_NUM-1:0] cfg_wdata;
    logic                  cfg_clr;
    logic                  req_valid;
    logic [CFG_AW-1:0]     req_cfg_id;
    logic                  req_ready;
    logic                  in_fire;
    logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1];
    logic                  out_valid;
    logic [CFG_AW-1:0]     out_cfg_id;
    logic                  busy;
    logic                  cfg_err;
    logic                  req_err;

    modport master (
        output cfg_we, cfg_waddr, cfg_wstage, cfg_wdata, cfg_clr,
        output req_valid, req_cfg_id,
        input  req_ready, in_fire, switch_set, out_valid, out_cfg_id,
        input  busy, cfg_err, req_err
    );

    modport slave (
        input  cfg_we, cfg_waddr, cfg_wstage, cfg_wdata, cfg_clr,
        input  req_valid, req_cfg_id,
        output req_ready, in_fire, switch_set, out_valid, out_cfg_id,
        output busy, cfg_err, req_err
    );
endinterface

// File: rtl/net_cfg_sequencer.sv
// rtl/net_cfg_sequencer.sv - skews stored per-stage switch words alongside beats in a pipelined switching network
module net_cfg_sequencer #(
    parameter int SIZE       = 32,
    parameter int SWITCH_NUM = SIZE / 2,
    parameter int STAGE_NUM  = 2 * $clog2(SIZE) - 1,
    parameter int CFG_DEPTH  = 8,
    parameter int CFG_AW     = $clog2(CFG_DEPTH),
    parameter int SAW        = $clog2(STAGE_NUM)
) (
    input  logic               clk,
    input  logic               rst_n,
    net_cfg_sequencer_if.slave bus
);
    localparam int                 CNT_W      = $clog2(STAGE_NUM + 2);
    localparam logic [SAW-1:0]     STAGE_LAST = SAW'(STAGE_NUM - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [SWITCH_NUM-1:0] cfg_tbl [0:CFG_DEPTH-1][0:STAGE_NUM-1];
    logic [CFG_DEPTH-1:0]  entry_vld;
    logic [STAGE_NUM:0]    vld_sr;
    logic [CFG_AW-1:0]     id_sr [0:STAGE_NUM];
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  cfg_req;
    logic                  tbl_open;
    logic                  fire;
    logic                  retire;
    logic                  cfg_err_q;
    logic                  req_err_q;

    assign cfg_req  = bus.cfg_we | bus.cfg_clr;
    assign tbl_open = (state == IDLE);

    // Table maintenance wins over a same-cycle beat, and nothing is accepted in reset.
    assign bus.req_ready  = rst_n & ~(tbl_open & cfg_req);
    assign fire           = bus.req_valid & bus.req_ready;
    assign bus.in_fire    = fire;
    assign retire         = vld_sr[STAGE_NUM];
    assign bus.out_valid  = retire;
    assign bus.out_cfg_id = id_sr[STAGE_NUM];
    assign bus.busy       = (count != '0);
    assign bus.cfg_err    = cfg_err_q;
    assign bus.req_err    = req_err_q;

    always_comb begin
        count_next = count;
        if (fire && !retire) begin
            count_next = count + CNT_ONE;
        end else if (!fire && retire) begin
            count_next = count - CNT_ONE;
        end
    end

    // Each stage reads the word belonging to the beat currently inside it.
    always_comb begin
        for (int k = 0; k < STAGE_NUM; k++) begin
            bus.switch_set[k] = vld_sr[k] ? cfg_tbl[id_sr[k]][k] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CFG_DEPTH; i++) begin
                for (int k = 0; k < STAGE_NUM; k++) begin
                    cfg_tbl[i][k] <= '0;
                end
            end
            entry_vld <= '0;
        end else if (tbl_open && bus.cfg_clr) begin
            for (int i = 0; i < CFG_DEPTH; i++) begin
                for (int k = 0; k < STAGE_NUM; k++) begin
                    cfg_tbl[i][k] <= '0;
                end
            end
            entry_vld <= '0;
        end else if (tbl_open && bus.cfg_we && bus.cfg_wstage <= STAGE_LAST) begin
            cfg_tbl[bus.cfg_waddr][bus.cfg_wstage] <= bus.cfg_wdata;
            entry_vld[bus.cfg_waddr]               <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
            for (int k = 0; k <= STAGE_NUM; k++) begin
                id_sr[k] <= '0;
            end
        end else begin
            vld_sr <= {vld_sr[STAGE_NUM-1:0], fire};
            if (fire) begin
                id_sr[0] <= bus.req_cfg_id;
            end
            for (int k = 0; k < STAGE_NUM; k++) begin
                id_sr[k+1] <= id_sr[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            cfg_err_q <= 1'b0;
            req_err_q <= 1'b0;
        end else begin
            count     <= count_next;
            req_err_q <= fire & ~entry_vld[bus.req_cfg_id];
            // A clear shadows a bad-stage write, so only a lone write can be out of range.
            cfg_err_q <= cfg_req & (~tbl_open |
                         (~bus.cfg_clr & (bus.cfg_wstage > STAGE_LAST)));
            case (state)
                IDLE: begin
                    if (fire) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!fire && count_next == '0) begin
                        state <= IDLE;
                    end else if (!bus.req_valid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fire) begin
                        state <= RUN;
                    end else if (count_next == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_net_cfg_sequencer.sv
// tb/tb_net_cfg_sequencer.sv - randomized scoreboard bench for net_cfg_sequencer
`timescale 1ns/1ps
module tb_net_cfg_sequencer;
    localparam int SWITCH_NUM = 16;
    localparam int STAGE_NUM  = 9;
    localparam int CFG_DEPTH  = 8;
    localparam int CFG_AW     = 3;
    localparam int SAW        = 4;
    localparam int LAT        = STAGE_NUM + 1;
    localparam int MAXC       = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    net_cfg_sequencer_if #(.SWITCH_NUM(SWITCH_NUM), .STAGE_NUM(STAGE_NUM),
                           .CFG_AW(CFG_AW), .SAW(SAW)) bus ();

    net_cfg_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int due;
        int id;
    } beat_t;

    logic [SWITCH_NUM-1:0] mtbl [CFG_DEPTH][STAGE_NUM];
    bit                    mvalid [CFG_DEPTH];
    int                    acc_id [MAXC];
    bit                    exp_ready [MAXC];
    bit                    exp_cfgerr [MAXC];
    bit                    exp_reqerr [MAXC];
    beat_t                 out_q [$];
    int                    cyc    = 0;
    int                    checks = 0;
    int                    passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic void clear_model();
        for (int i = 0; i < CFG_DEPTH; i++) begin
            mvalid[i] = 1'b0;
            for (int k = 0; k < STAGE_NUM; k++) mtbl[i][k] = '0;
        end
    endfunction

    // A beat accepted in cycle t is counted in flight during cycles t+1 .. t+LAT.
    function automatic bit idle_at(input int c);
        for (int t = c - LAT; t < c; t++) begin
            if (t >= 0 && acc_id[t] >= 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Stage k works on the beat accepted k+1 cycles earlier.
    function automatic logic [SWITCH_NUM-1:0] exp_sw(input int c, input int k);
        int t;
        t = c - 1 - k;
        if (t < 0 || acc_id[t] < 0) return '0;
        return mtbl[acc_id[t]][k];
    endfunction

    task automatic drive(input bit rst, input bit we, input int addr, input int stage,
                         input logic [15:0] data, input bit clr, input bit rv, input int id);
        int c;
        bit idle;
        bit rdy;
        @(posedge clk);
        #1;
        c = cyc;
        rst_n          = !rst;
        bus.cfg_we     = we;
        bus.cfg_waddr  = CFG_AW'(addr);
        bus.cfg_wstage = SAW'(stage);
        bus.cfg_wdata  = data;
        bus.cfg_clr    = clr;
        bus.req_valid  = rv;
        bus.req_cfg_id = CFG_AW'(id);
        acc_id[c] = -1;
        if (rst) begin
            for (int t = c - LAT; t < c; t++) if (t >= 0) acc_id[t] = -1;
            out_q.delete();
            exp_ready[c]    = 1'b0;
            exp_cfgerr[c]   = 1'b0;
            exp_reqerr[c]   = 1'b0;
            exp_cfgerr[c+1] = 1'b0;
            exp_reqerr[c+1] = 1'b0;
            clear_model();
        end else begin
            idle = idle_at(c);
            rdy  = !(idle && (we || clr));
            exp_ready[c] = rdy;
            if (rv && rdy) begin
                acc_id[c] = id;
                out_q.push_back('{c + LAT, id});
                exp_reqerr[c+1] = !mvalid[id];
            end
            if (we || clr) begin
                if (!idle) exp_cfgerr[c+1] = 1'b1;
                else if (clr) clear_model();
                else if (stage >= STAGE_NUM) exp_cfgerr[c+1] = 1'b1;
                else begin
                    mtbl[addr][stage] = data;
                    mvalid[addr]      = 1'b1;
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive(0, 0, 0, 0, 16'h0, 0, 0, 0);
    endtask

    task automatic request(input int id);
        drive(0, 0, 0, 0, 16'h0, 0, 1, id);
    endtask

    always @(negedge clk) begin : monitor
        int c;
        beat_t b;
        c = cyc;
        if (c >= 1 && c < MAXC - 1) begin
            check("req_ready", bus.req_ready, exp_ready[c]);
            check("in_fire", bus.in_fire, acc_id[c] >= 0);
            for (int k = 0; k < STAGE_NUM; k++)
                check($sformatf("switch_set[%0d]", k), bus.switch_set[k], exp_sw(c, k));
            check("busy", bus.busy, !idle_at(c));
            check("cfg_err", bus.cfg_err, exp_cfgerr[c]);
            check("req_err", bus.req_err, exp_reqerr[c]);
            if (!rst_n) check("out_cfg_id_rst", bus.out_cfg_id, 0);
            if (bus.out_valid) begin
                if (out_q.size() == 0) check("out_valid_spurious", bus.out_valid, 0);
                else begin
                    b = out_q.pop_front();
                    check("out_valid_cycle", c, b.due);
                    check("out_cfg_id", bus.out_cfg_id, b.id);
                end
            end else if (out_q.size() > 0 && out_q[0].due <= c) begin
                b = out_q.pop_front();
                check("out_valid_missing", bus.out_valid, 1);
            end
        end
    end

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            acc_id[i]     = -1;
            exp_ready[i]  = 1'b0;
            exp_cfgerr[i] = 1'b0;
            exp_reqerr[i] = 1'b0;
        end
        clear_model();
        bus.cfg_we = 0; bus.cfg_waddr = '0; bus.cfg_wstage = '0; bus.cfg_wdata = '0;
        bus.cfg_clr = 0; bus.req_valid = 0; bus.req_cfg_id = '0;

        repeat (3) drive(1, 0, 0, 0, 16'h0, 0, 0, 0);
        idle_cycles(2);
        for (int k = 0; k < STAGE_NUM; k++) drive(0, 1, 2, k, 16'(1 << k), 0, 0, 0);
        for (int k = 0; k < STAGE_NUM; k++) drive(0, 1, 5, k, 16'hFFFF, 0, 0, 0);
        idle_cycles(2);

        request(2);
        idle_cycles(12);

        for (int i = 0; i < 20; i++) request((i % 2) ? 5 : 2);
        idle_cycles(12);

        for (int i = 0; i < 6; i++) drive(0, i == 3, 5, 0, 16'h0000, i == 4, 1, 2);
        idle_cycles(12);
        request(5);
        idle_cycles(12);

        drive(0, 1, 5, 3, 16'h1234, 0, 1, 5);
        request(5);
        idle_cycles(12);

        drive(0, 1, 4, 9, 16'hABCD, 0, 0, 0);
        drive(0, 1, 4, 15, 16'hABCD, 0, 0, 0);
        drive(0, 1, 4, 2, 16'h5A5A, 1, 0, 0);
        idle_cycles(2);
        request(4);
        request(7);
        idle_cycles(12);

        repeat (300) begin
            int r;
            r = $urandom_range(0, 99);
            drive(0, r < 10, $urandom_range(0, 7), $urandom_range(0, 10), 16'($urandom),
                  r >= 97, $urandom_range(0, 99) < 55, $urandom_range(0, 7));
        end
        idle_cycles(12);

        repeat (4) request($urandom_range(0, 7));
        drive(1, 0, 0, 0, 16'h0, 0, 1, 2);
        drive(1, 0, 0, 0, 16'h0, 0, 0, 0);
        idle_cycles(15);
        request(2);
        idle_cycles(12);

        check("scoreboard_empty", out_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/net_cfg_sequencer.md
Name: net_cfg_sequencer

Overview:
- Configuration sequencer for the pipelined multistage switching network: 9 switch stages with a register between each pair.
- Holds a programmable table of permutation configurations and accepts one data-beat request per cycle, each tagged with a config ID.
- Skews that config's per-stage switch words so each stage sees the right setting while the beat is inside that stage.
- Flags when the permuted beat reaches the network output.

Parameters:
- SIZE, 32, network port count.
- SWITCH_NUM, 16, 2x2 switches per stage (SIZE/2).
- STAGE_NUM, 9, switch stages (2*log2(SIZE)-1).
- CFG_DEPTH, 8, stored configurations.
- CFG_AW, 3, log2(CFG_DEPTH).
- SAW, 4, stage index width (ceil log2 STAGE_NUM).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  table write strobe
- cfg_waddr  in  CFG_AW  config entry to write
- cfg_wstage  in  SAW  stage word within the entry
- cfg_wdata  in  SWITCH_NUM  switch word (bit=1 cross, 0 bar)
- cfg_clr  in  1  invalidate all entries
- req_valid  in  1  data beat present on network i_port this cycle
- req_cfg_id  in  CFG_AW  config for that beat
- req_ready  out  1  beat accepted when req_valid&req_ready
- in_fire  out  1  req_valid&req_ready; datapath gates i_port with it
- switch_set  out  [0:STAGE_NUM-1] x SWITCH_NUM  per-stage switch control
- out_valid  out  1  network o_port carries an accepted beat
- out_cfg_id  out  CFG_AW  config ID of the beat on o_port
- busy  out  1  any beat in flight
- cfg_err  out  1  one-cycle pulse: write or clear dropped
- req_err  out  1  one-cycle pulse: accepted beat used an unprogrammed entry

Behaviour:
- Reset, asynchronous: all shift regs, table words, entry-valid bits and the in-flight counter clear; FSM goes to IDLE.
- While rst_n is low, all outputs are 0, including req_ready.
- Table: CFG_DEPTH x STAGE_NUM words of SWITCH_NUM bits, plus one entry-valid bit per entry.
- An entry becomes valid on its first write of any stage; unwritten stages read 0.
- Writes and clears take effect only in IDLE. cfg_wstage >= STAGE_NUM: write dropped, cfg_err pulses.
- In RUN or DRAIN, cfg_we or cfg_clr is dropped and cfg_err pulses the next cycle. A write and a clear in the same IDLE cycle: clear wins.
- req_ready = !(state==IDLE && (cfg_we||cfg_clr)). Table updates take priority over a same-cycle request.
- Pipeline tracking: vld_sr[0:STAGE_NUM] and id_sr[0:STAGE_NUM].
  - On in_fire in cycle t: vld_sr[0]<=1, id_sr[0]<=req_cfg_id. Otherwise vld_sr[0]<=0.
  - Each cycle [k+1]<=[k].
  - Stage k processes the beat in cycle t+1+k.
- switch_set[k] = vld_sr[k] ? table[id_sr[k]][k] : 0.
  - Read combinationally from table registers.
  - Unprogrammed entry: all-zero words (bar) and req_err pulses in cycle t+1.
- out_valid = vld_sr[STAGE_NUM], out_cfg_id = id_sr[STAGE_NUM].
- Latency: request at cycle t gives out_valid at t+STAGE_NUM+1 (10 cycles), matching the network input, inter-stage and output registers.
- Throughput is 1 beat/cycle. Back-to-back beats with different IDs are fully independent per stage; there is no bubble and no flush on a config change.
- In-flight counter (0..STAGE_NUM+1):
  - +1 on in_fire, -1 on out_valid; both in the same cycle leaves it unchanged.
  - busy = (count!=0).
- FSM:
  - IDLE -> RUN on in_fire.
  - RUN -> DRAIN when req_valid is low and count > 0.
  - DRAIN -> RUN on in_fire.
  - DRAIN -> IDLE when count reaches 0 after the decrement, with no in_fire.
  - RUN -> IDLE when count reaches 0 with no in_fire.
- Reset mid-flight: all in-flight beats are discarded and out_valid never asserts for them.

Test Plan:
- Reset, then write entry 2 with stage k word = 16'h0001<<k for k=0..8; request id 2 at cycle 0 -> switch_set[k]=1<<k exactly in cycle 1+k, 0 elsewhere; out_valid=1 and out_cfg_id=2 at cycle 10; busy high cycles 1-10.
- 20 back-to-back beats alternating id 2/5 (entry 5 = all 16'hFFFF) -> each stage alternates 16'h0001<<k / FFFF every cycle; out_valid high for 20 consecutive cycles starting at cycle 10; no req_ready drop.
- cfg_we to entry 5 during RUN -> cfg_err pulse; entry 5 contents unchanged on a later request.
- Same-cycle cfg_we and req_valid in IDLE -> req_ready=0, write applied; beat accepted next cycle with the new contents.
- Request id 7 never written -> all switch_set 0 for that beat, req_err pulse at t+1, out_valid still at t+10.
- Assert rst_n low with 4 beats in flight -> all outputs 0 immediately; no out_valid after release; busy=0.
